// File: rtl/pmem_burst_arbiter_pkg.sv
// Shared types and constants for the I/D-cache physical-memory burst arbiter.
package pmem_burst_arbiter_pkg;

    localparam int LINE_W     = 256;
    localparam int BEAT_W     = 64;
    localparam int BEATS      = LINE_W / BEAT_W;
    localparam int OFFSET_W   = 5;
    localparam int BEAT_CNT_W = $clog2(BEATS);
    localparam int BEAT_SHIFT = $clog2(BEAT_W);

    typedef enum logic [2:0] {
        IDLE,
        I_READ,
        D_READ,
        D_WRITE,
        DONE
    } arb_state_t;

    // Clears the byte-offset bits so every burst starts on a line boundary.
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & ~32'((1 << OFFSET_W) - 1);
    endfunction

endpackage

// File: rtl/pmem_burst_arbiter_if.sv
// Bundle of the I-cache line, D-cache line and physical-memory burst signals.
//
// Handshake: a cache raises its request (icline_read / dcline_read /
// dcline_write) with address and wdata and holds them stable until its
// *_resp pulses for one cycle; it drops the request in the cycle after.
// pmem_read / pmem_write stay high for a whole burst with a constant
// pmem_address; memory pulses pmem_resp once per accepted 64-bit beat.
interface pmem_burst_arbiter_if;
    import pmem_burst_arbiter_pkg::*;

    logic [31:0]       icline_address;
    logic              icline_read;
    logic [LINE_W-1:0] icline_rdata;
    logic              icline_resp;

    logic [31:0]       dcline_address;
    logic              dcline_read;
    logic              dcline_write;
    logic [LINE_W-1:0] dcline_wdata;
    logic [LINE_W-1:0] dcline_rdata;
    logic              dcline_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [31:0]       pmem_address;
    logic [BEAT_W-1:0] pmem_wdata;
    logic [BEAT_W-1:0] pmem_rdata;
    logic              pmem_resp;

    // Arbiter side.
    modport slave (
        input  icline_address, icline_read,
        output icline_rdata, icline_resp,
        input  dcline_address, dcline_read, dcline_write, dcline_wdata,
        output dcline_rdata, dcline_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    // Caches plus physical memory, seen from outside the arbiter.
    modport master (
        output icline_address, icline_read,
        input  icline_rdata, icline_resp,
        output dcline_address, dcline_read, dcline_write, dcline_wdata,
        input  dcline_rdata, dcline_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/pmem_burst_arbiter_burst_serdes.sv
// Line buffer and beat counter: assembles read beats into a line and
// slices the latched write line into beats.
module burst_serdes
    import pmem_burst_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [LINE_W-1:0] load_data,
    input  logic              beat_rd,
    input  logic              beat_wr,
    input  logic [BEAT_W-1:0] rd_beat,
    output logic [LINE_W-1:0] line,
    output logic [BEAT_W-1:0] wr_beat,
    output logic              last_beat
);

    logic [BEAT_CNT_W-1:0]            cnt;
    logic [BEAT_CNT_W+BEAT_SHIFT-1:0] base;

    assign base = {cnt, {BEAT_SHIFT{1'b0}}};

    // Count accepted beats and insert read beats at the current slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            line <= '0;
        end else begin
            if (clear) begin
                cnt <= '0;
            end else if (beat_rd || beat_wr) begin
                cnt <= cnt + 1'b1;
            end
            if (load) begin
                line <= load_data;
            end else if (beat_rd) begin
                line[base +: BEAT_W] <= rd_beat;
            end
        end
    end

    assign wr_beat   = line[base +: BEAT_W];
    assign last_beat = (cnt == BEAT_CNT_W'(BEATS - 1));

endmodule

// File: rtl/pmem_burst_arbiter.sv
// Arbitrates the single burst memory port between I-cache and D-cache line
// requests, alternating on ties, one line transaction at a time.
module pmem_burst_arbiter
    import pmem_burst_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    pmem_burst_arbiter_if.slave  bus,
    output arb_state_t           state_dbg
);

    arb_state_t        state;
    logic              last_i;
    logic              grant_i;
    logic [31:0]       addr_q;

    logic              i_req;
    logic              d_req;
    logic              pick_d;
    logic              pick_i;
    logic              grant;
    logic              grant_wr;
    logic              beat_rd;
    logic              beat_wr;
    logic              last_beat;
    logic [LINE_W-1:0] line;
    logic [BEAT_W-1:0] wr_beat;

    assign i_req    = bus.icline_read;
    assign d_req    = bus.dcline_read | bus.dcline_write;
    // Data wins when alone or when instruction was served last.
    assign pick_d   = (state == IDLE) && d_req && (!i_req || last_i);
    assign pick_i   = (state == IDLE) && i_req && !pick_d;
    assign grant    = pick_d | pick_i;
    assign grant_wr = pick_d & bus.dcline_write;

    assign beat_rd  = bus.pmem_resp && ((state == I_READ) || (state == D_READ));
    assign beat_wr  = bus.pmem_resp && (state == D_WRITE);

    burst_serdes u_serdes (
        .clk       (clk),
        .rst       (rst),
        .clear     (grant),
        .load      (grant_wr),
        .load_data (bus.dcline_wdata),
        .beat_rd   (beat_rd),
        .beat_wr   (beat_wr),
        .rd_beat   (bus.pmem_rdata),
        .line      (line),
        .wr_beat   (wr_beat),
        .last_beat (last_beat)
    );

    // Transaction FSM with grant side, fairness flag and address latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last_i  <= 1'b1;
            grant_i <= 1'b0;
            addr_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        state   <= bus.dcline_write ? D_WRITE : D_READ;
                        grant_i <= 1'b0;
                        addr_q  <= line_align(bus.dcline_address);
                    end else if (pick_i) begin
                        state   <= I_READ;
                        grant_i <= 1'b1;
                        addr_q  <= line_align(bus.icline_address);
                    end
                end
                I_READ, D_READ, D_WRITE: begin
                    if (bus.pmem_resp && last_beat) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    last_i <= grant_i;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pmem_read    = (state == I_READ) || (state == D_READ);
    assign bus.pmem_write   = (state == D_WRITE);
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wr_beat;
    assign bus.icline_resp  = (state == DONE) && grant_i;
    assign bus.dcline_resp  = (state == DONE) && !grant_i;
    assign bus.icline_rdata = line;
    assign bus.dcline_rdata = line;
    assign state_dbg        = state;

endmodule

// File: tb/tb_pmem_burst_arbiter.sv
// Directed bench for pmem_burst_arbiter with a response scoreboard.
module tb_pmem_burst_arbiter;
    import pmem_burst_arbiter_pkg::*;

    localparam int EW = LINE_W + 2;
    localparam logic [1:0] K_IRD = 2'd0;
    localparam logic [1:0] K_DRD = 2'd1;
    localparam logic [1:0] K_DWR = 2'd2;

    logic       clk;
    logic       rst;
    arb_state_t state_dbg;
    int         total;
    int         bad;
    logic [EW-1:0] exp_q[$];

    pmem_burst_arbiter_if bus();

    pmem_burst_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every cache resp pops one expected transaction.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst && (bus.icline_resp || bus.dcline_resp)) begin
            chk("resp_onehot", LINE_W'(bus.icline_resp & bus.dcline_resp), '0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got i=%0b d=%0b expected none", bus.icline_resp, bus.dcline_resp);
            end else begin
                e = exp_q.pop_front();
                chk("resp_side", LINE_W'(bus.dcline_resp), LINE_W'(e[EW-1:LINE_W] != K_IRD));
                if (e[EW-1:LINE_W] == K_IRD) chk("icline_rdata", bus.icline_rdata, e[LINE_W-1:0]);
                if (e[EW-1:LINE_W] == K_DRD) chk("dcline_rdata", bus.dcline_rdata, e[LINE_W-1:0]);
            end
        end
    end

    // Memory-side driver: waits for the burst, checks address/strobes/wdata,
    // then delivers nb beats with the given idle gaps before beats 1..3.
    task automatic serve_burst(input bit wr, input logic [31:0] exp_addr, input logic [LINE_W-1:0] data,
                               input int nb, input int g1, input int g2, input int g3);
        int n;
        int gap;
        n = 0;
        while (!(bus.pmem_read || bus.pmem_write) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("grant_timeout", '0, 1);
            return;
        end
        chk("pmem_address", LINE_W'(bus.pmem_address), LINE_W'(exp_addr));
        chk("pmem_strobes", LINE_W'({bus.pmem_read, bus.pmem_write}), LINE_W'(wr ? 2'b01 : 2'b10));
        for (int k = 0; k < nb; k++) begin
            gap = (k == 1) ? g1 : (k == 2) ? g2 : (k == 3) ? g3 : 0;
            repeat (gap) begin
                @(negedge clk);
                chk("addr_stable", LINE_W'(bus.pmem_address), LINE_W'(exp_addr));
                chk("strobe_held", LINE_W'({bus.pmem_read, bus.pmem_write}), LINE_W'(wr ? 2'b01 : 2'b10));
            end
            if (wr) chk("pmem_wdata", LINE_W'(bus.pmem_wdata), LINE_W'(data[k*BEAT_W +: BEAT_W]));
            bus.pmem_rdata = data[k*BEAT_W +: BEAT_W];
            bus.pmem_resp  = 1'b1;
            @(negedge clk);
            bus.pmem_resp  = 1'b0;
        end
    endtask

    // Requester side: wait for its resp, then drop the request.
    task automatic wait_resp(input bit is_d);
        int n;
        n = 0;
        while (!(is_d ? bus.dcline_resp : bus.icline_resp) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk(is_d ? "dresp_timeout" : "iresp_timeout", '0, 1);
        chk("strobes_in_done", LINE_W'({bus.pmem_read, bus.pmem_write}), '0);
        if (is_d) begin
            bus.dcline_read  = 1'b0;
            bus.dcline_write = 1'b0;
        end else begin
            bus.icline_read  = 1'b0;
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_pmem_read", LINE_W'(bus.pmem_read), '0);
        chk("rst_pmem_write", LINE_W'(bus.pmem_write), '0);
        chk("rst_pmem_address", LINE_W'(bus.pmem_address), '0);
        chk("rst_pmem_wdata", LINE_W'(bus.pmem_wdata), '0);
        chk("rst_icline_resp", LINE_W'(bus.icline_resp), '0);
        chk("rst_dcline_resp", LINE_W'(bus.dcline_resp), '0);
        chk("rst_line", bus.icline_rdata, '0);
        chk("rst_state", LINE_W'(state_dbg), LINE_W'(IDLE));
    endtask

    // Directed stimulus.
    initial begin
        logic [LINE_W-1:0] line_a;
        logic [LINE_W-1:0] line_b;
        logic [LINE_W-1:0] line_c;
        logic [LINE_W-1:0] wline;
        total = 0;
        bad   = 0;
        rst = 1'b1;
        bus.icline_address = '0;
        bus.icline_read    = 1'b0;
        bus.dcline_address = '0;
        bus.dcline_read    = 1'b0;
        bus.dcline_write   = 1'b0;
        bus.dcline_wdata   = '0;
        bus.pmem_rdata     = '0;
        bus.pmem_resp      = 1'b0;
        line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        line_b = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                  64'hA5A5_5A5A_A5A5_5A5A, 64'h0F0F_F0F0_1234_5678};
        line_c = {64'hCAFE_0003_0000_0003, 64'hCAFE_0002_0000_0002,
                  64'hCAFE_0001_0000_0001, 64'hCAFE_0000_0000_0000};
        wline  = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                  64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);

        // Tie after reset: data first, then instruction.
        bus.icline_address = 32'h0000_3001;
        bus.icline_read    = 1'b1;
        bus.dcline_address = 32'h0000_2048;
        bus.dcline_read    = 1'b1;
        exp_q.push_back({K_DRD, line_b});
        exp_q.push_back({K_IRD, line_c});
        serve_burst(1'b0, 32'h0000_2040, line_b, 4, 0, 0, 0);
        wait_resp(1'b1);
        serve_burst(1'b0, 32'h0000_3000, line_c, 4, 0, 0, 0);
        wait_resp(1'b0);
        @(negedge clk);

        // Repeated tie: instruction went last, so data wins again.
        bus.icline_address = 32'h0000_3001;
        bus.icline_read    = 1'b1;
        bus.dcline_address = 32'h0000_6060;
        bus.dcline_read    = 1'b1;
        exp_q.push_back({K_DRD, line_a});
        exp_q.push_back({K_IRD, line_b});
        serve_burst(1'b0, 32'h0000_6060, line_a, 4, 0, 0, 0);
        wait_resp(1'b1);
        serve_burst(1'b0, 32'h0000_3000, line_b, 4, 0, 0, 0);
        wait_resp(1'b0);
        @(negedge clk);

        // I-fill alone.
        bus.icline_address = 32'h0000_1234;
        bus.icline_read    = 1'b1;
        exp_q.push_back({K_IRD, line_a});
        serve_burst(1'b0, 32'h0000_1220, line_a, 4, 0, 0, 0);
        wait_resp(1'b0);
        @(negedge clk);

        // D write-back.
        bus.dcline_address = 32'h8000_0047;
        bus.dcline_wdata   = wline;
        bus.dcline_write   = 1'b1;
        exp_q.push_back({K_DWR, wline});
        serve_burst(1'b1, 32'h8000_0040, wline, 4, 0, 0, 0);
        wait_resp(1'b1);
        @(negedge clk);

        // Stalled beats with 0, 3 and 7 idle cycles between pulses.
        bus.dcline_address = 32'h0001_00FF;
        bus.dcline_read    = 1'b1;
        exp_q.push_back({K_DRD, line_c});
        serve_burst(1'b0, 32'h0001_00E0, line_c, 4, 0, 3, 7);
        wait_resp(1'b1);
        @(negedge clk);

        // Reset after beat 2: partial line discarded, no resp.
        bus.icline_address = 32'h0000_4010;
        bus.icline_read    = 1'b1;
        serve_burst(1'b0, 32'h0000_4000, line_b, 2, 0, 0, 0);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        @(negedge clk);
        bus.icline_read = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_reset_idle", LINE_W'(state_dbg), LINE_W'(IDLE));
        bus.icline_address = 32'h0000_5008;
        bus.icline_read    = 1'b1;
        exp_q.push_back({K_IRD, line_a});
        serve_burst(1'b0, 32'h0000_5000, line_a, 4, 1, 0, 2);
        wait_resp(1'b0);
        @(negedge clk);

        // Spurious pmem_resp in IDLE, then read+write together grants the write.
        bus.pmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        bus.pmem_resp  = 1'b1;
        @(negedge clk);
        bus.pmem_resp  = 1'b0;
        chk("spurious_state", LINE_W'(state_dbg), LINE_W'(IDLE));
        chk("spurious_strobes", LINE_W'({bus.pmem_read, bus.pmem_write}), '0);
        bus.dcline_address = 32'h0000_9999;
        bus.dcline_wdata   = line_b;
        bus.dcline_read    = 1'b1;
        bus.dcline_write   = 1'b1;
        exp_q.push_back({K_DWR, line_b});
        serve_burst(1'b1, 32'h0000_9980, line_b, 4, 2, 0, 1);
        wait_resp(1'b1);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", LINE_W'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
